irq_stack_seq: RTL and testbench

Interrupt entry/exit sequencer for the AVR core. It sits between the interrupt controller / instruction decoder and the internal I/O register file plus data RAM. On an accepted interrupt it pushes the return PC onto the stack, clears SREG.I and loads the vector address. On RETI it pops the PC, sets SREG.I and reloads the PC. It drives the register file's stack-pointer count interface (`sp_en`/`sp_ndown_up`) and its SREG flag-write interface; it never writes SPL/SPH through I/O.

---
 rtl/irq_stack_seq.sv | 186 ++++++++++++++++++
 tb/tb_irq_stack_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_stack_seq.sv
// AVR interrupt entry/exit sequencer: pushes/pops the return PC through the
// register-file SP count interface and toggles SREG.I on entry and RETI.
`timescale 1ns/1ps
module irq_stack_seq #(
  parameter int pc22b = 0
) (
  input  logic        cp2,
  input  logic        ireset,
  input  logic        cp2en,
  input  logic        irq_req,
  input  logic [5:0]  irq_vec,
  input  logic        reti_req,
  input  logic [21:0] pc_in,
  input  logic [15:0] sp_in,
  input  logic        sreg_i,
  input  logic [7:0]  ram_din,
  output logic        sp_en,
  output logic        sp_ndown_up,
  output logic [7:0]  sreg_fl_in,
  output logic [7:0]  sreg_fl_wr_en,
  output logic [15:0] ram_adr,
  output logic [7:0]  ram_dout,
  output logic        ram_we,
  output logic        ram_re,
  output logic [21:0] pc_out,
  output logic        pc_load,
  output logic        irq_ack,
  output logic        busy,
  output logic        done
);
  localparam int NB = 2 + pc22b;

  typedef enum logic [3:0] {
    IDLE, PUSH0, PUSH1, PUSH2, VECT,
    INC0, RD0, INC1, RD1, INC2, RD2, FIN
  } state_t;

  state_t      state, state_nxt;
  logic [21:0] pc_lat;
  logic [5:0]  vec_lat;
  logic [21:0] pc_asm, asm_cur;
  logic        cap_vld;
  logic [1:0]  cap_idx;
  logic        accept, rd_now, en;
  logic [1:0]  rd_byte;
  logic        unused_bits;

  // Stack byte 2 only carries PC[21:16]; the top two RAM bits are don't-care.
  assign unused_bits = ^ram_din[7:6];
  assign en          = cp2en & ~ireset;
  assign busy        = (state != IDLE);
  assign accept      = (state == IDLE) && !reti_req && irq_req && sreg_i;

  // Pops run highest byte first, so pair 0 reads byte NB-1.
  always_comb begin
    rd_now  = 1'b0;
    rd_byte = 2'd0;
    case (state)
      RD0:     begin rd_now = 1'b1; rd_byte = 2'(NB - 1); end
      RD1:     begin rd_now = 1'b1; rd_byte = 2'(NB - 2); end
      RD2:     begin rd_now = 1'b1; rd_byte = 2'd0;       end
      default: ;
    endcase
  end

  // Read data lands one enabled cycle after RDk; merge it combinationally so
  // FIN can present the full PC in the same cycle the last byte arrives.
  always_comb begin
    asm_cur = pc_asm;
    if (cap_vld) begin
      case (cap_idx)
        2'd0:    asm_cur[7:0]   = ram_din;
        2'd1:    asm_cur[15:8]  = ram_din;
        default: asm_cur[21:16] = ram_din[5:0];
      endcase
    end
    if (pc22b == 0) asm_cur[21:16] = 6'd0;
  end

  always_ff @(posedge cp2) begin
    if (ireset) begin
      state   <= IDLE;
      pc_lat  <= '0;
      vec_lat <= '0;
      pc_asm  <= '0;
      cap_vld <= 1'b0;
      cap_idx <= 2'd0;
    end else if (cp2en) begin
      state   <= state_nxt;
      pc_asm  <= asm_cur;
      cap_vld <= rd_now;
      cap_idx <= rd_byte;
      if (accept) begin
        pc_lat  <= (pc22b != 0) ? pc_in : {6'd0, pc_in[15:0]};
        vec_lat <= irq_vec;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    sp_en         = 1'b0;
    sp_ndown_up   = 1'b0;
    sreg_fl_in    = 8'd0;
    sreg_fl_wr_en = 8'd0;
    ram_adr       = 16'd0;
    ram_dout      = 8'd0;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    pc_out        = 22'd0;
    pc_load       = 1'b0;
    irq_ack       = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (reti_req) state_nxt = INC0;
        else if (accept) begin
          irq_ack   = 1'b1;
          state_nxt = PUSH0;
        end
      end
      PUSH0, PUSH1, PUSH2: begin
        sp_en   = 1'b1;
        ram_we  = 1'b1;
        ram_adr = sp_in;
        case (state)
          PUSH0: begin
            ram_dout         = pc_lat[7:0];
            sreg_fl_wr_en[7] = 1'b1;
            state_nxt        = PUSH1;
          end
          PUSH1: begin
            ram_dout  = pc_lat[15:8];
            state_nxt = (pc22b != 0) ? PUSH2 : VECT;
          end
          default: begin
            ram_dout  = {2'b00, pc_lat[21:16]};
            state_nxt = VECT;
          end
        endcase
      end
      VECT: begin
        pc_load   = 1'b1;
        done      = 1'b1;
        pc_out    = {15'd0, vec_lat, 1'b0};
        state_nxt = IDLE;
      end
      INC0, INC1, INC2: begin
        sp_en       = 1'b1;
        sp_ndown_up = 1'b1;
        state_nxt   = (state == INC0) ? RD0 : (state == INC1) ? RD1 : RD2;
      end
      RD0, RD1, RD2: begin
        ram_re  = 1'b1;
        ram_adr = sp_in;
        if (state == RD0)                     state_nxt = INC1;
        else if (state == RD1 && pc22b != 0)  state_nxt = INC2;
        else                                  state_nxt = FIN;
      end
      FIN: begin
        pc_load          = 1'b1;
        done             = 1'b1;
        pc_out           = asm_cur;
        sreg_fl_wr_en[7] = 1'b1;
        sreg_fl_in[7]    = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A stalled or resetting cycle issues nothing; the step repeats later.
    if (!en) begin
      sp_en         = 1'b0;
      sp_ndown_up   = 1'b0;
      sreg_fl_in    = 8'd0;
      sreg_fl_wr_en = 8'd0;
      ram_adr       = 16'd0;
      ram_dout      = 8'd0;
      ram_we        = 1'b0;
      ram_re        = 1'b0;
      pc_out        = 22'd0;
      pc_load       = 1'b0;
      irq_ack       = 1'b0;
      done          = 1'b0;
    end
  end
endmodule

// File: tb/tb_irq_stack_seq.sv
// Scoreboard bench for irq_stack_seq: one instance per PC width, each with a
// small SP/SREG/RAM environment; a negedge monitor checks every active cycle.
`timescale 1ns/1ps
module tb_irq_stack_seq;
  typedef struct packed {
    logic        sp_en, dir;
    logic [7:0]  fl_in, fl_we;
    logic [15:0] adr;
    logic [7:0]  dout;
    logic        we, re;
    logic [21:0] pc;
    logic        load, ack, done;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ireset, cp2en, irq_req, reti_req;
  logic [5:0]  irq_vec;
  logic [21:0] pc_in;
  int          sel;
  logic        set_en, set_sreg;
  logic [15:0] set_sp;
  ev_t         q[$];
  int          checks = 0, errors = 0;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : gi
      logic [15:0] sp   = 16'd0;
      logic        sreg = 1'b0;
      logic [7:0]  rdat = 8'd0;
      logic [7:0]  mem [65536];
      logic        sp_en, dir, we, re, pc_load, ack, done, busy;
      logic [7:0]  fl_in, fl_we, dout;
      logic [15:0] adr;
      logic [21:0] pc_out;
      ev_t         act;
      irq_stack_seq #(.pc22b(g)) dut (
        .cp2(clk), .ireset(ireset), .cp2en(cp2en),
        .irq_req(irq_req && sel == g), .irq_vec(irq_vec),
        .reti_req(reti_req && sel == g), .pc_in(pc_in),
        .sp_in(sp), .sreg_i(sreg), .ram_din(rdat),
        .sp_en(sp_en), .sp_ndown_up(dir), .sreg_fl_in(fl_in),
        .sreg_fl_wr_en(fl_we), .ram_adr(adr), .ram_dout(dout),
        .ram_we(we), .ram_re(re), .pc_out(pc_out), .pc_load(pc_load),
        .irq_ack(ack), .busy(busy), .done(done));
      assign act = {sp_en, dir, fl_in, fl_we, adr, dout, we, re, pc_out, pc_load, ack, done};
      // Register-file and RAM stand-ins
      always @(posedge clk) begin
        if (set_en && sel == g) begin
          sp   <= set_sp;
          sreg <= set_sreg;
        end else begin
          if (sp_en)    sp   <= dir ? sp + 16'd1 : sp - 16'd1;
          if (fl_we[7]) sreg <= fl_in[7];
        end
        if (we) mem[adr] <= dout;
        if (re) rdat <= mem[adr];
      end
    end
  endgenerate

  always @(negedge clk) begin
    ev_t a, e;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? gi[0].act : gi[1].act;
      if (a != '0) begin
        checks++;
        if (i != sel || q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event inst %0d got %h", i, a);
        end else begin
          e = q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL event inst %0d got %h want %h", i, a, e);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic e_ack();
    ev_t e = '0; e.ack = 1'b1; q.push_back(e);
  endtask
  task automatic e_push(input logic [15:0] a, input logic [7:0] d, input bit first);
    ev_t e = '0; e.sp_en = 1'b1; e.we = 1'b1; e.adr = a; e.dout = d;
    if (first) e.fl_we = 8'h80;
    q.push_back(e);
  endtask
  task automatic e_vect(input logic [21:0] pc);
    ev_t e = '0; e.load = 1'b1; e.done = 1'b1; e.pc = pc; q.push_back(e);
  endtask
  task automatic e_inc();
    ev_t e = '0; e.sp_en = 1'b1; e.dir = 1'b1; q.push_back(e);
  endtask
  task automatic e_rd(input logic [15:0] a);
    ev_t e = '0; e.re = 1'b1; e.adr = a; q.push_back(e);
  endtask
  task automatic e_fin(input logic [21:0] pc);
    ev_t e = '0; e.load = 1'b1; e.done = 1'b1; e.pc = pc;
    e.fl_we = 8'h80; e.fl_in = 8'h80; q.push_back(e);
  endtask

  task automatic setenv(input int s, input logic [15:0] spv, input logic sr);
    @(posedge clk); #1;
    sel = s; set_sp = spv; set_sreg = sr; set_en = 1'b1;
    @(posedge clk); #1;
    set_en = 1'b0;
  endtask

  // Issue a request in cycle 0 and check the cycle in which done appears.
  task automatic run(input bit reti, input bit irq, input int want, input string nm);
    int n;
    bit seen = 0;
    @(posedge clk); #1;
    reti_req = reti; irq_req = irq;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 1) begin reti_req = 1'b0; irq_req = 1'b0; end
      if (gi[0].done || gi[1].done) begin seen = 1; break; end
    end
    chk(nm, seen ? n : -1, want);
    @(negedge clk);
    chk({nm, "_idle"}, {31'd0, gi[0].busy | gi[1].busy}, 0);
    chk({nm, "_drain"}, q.size(), 0);
  endtask

  initial begin
    int n;
    ireset = 1'b1; cp2en = 1'b1; irq_req = 1'b0; reti_req = 1'b0;
    irq_vec = '0; pc_in = '0; sel = 0; set_en = 1'b0; set_sp = '0; set_sreg = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out0", {31'd0, gi[0].act != '0}, 0);
    chk("reset_out1", {31'd0, gi[1].act != '0}, 0);
    chk("reset_busy", {30'd0, gi[1].busy, gi[0].busy}, 0);
    @(posedge clk); #1 ireset = 1'b0;

    // 1: entry, 16-bit PC
    setenv(0, 16'h10FF, 1'b1);
    irq_vec = 6'd5; pc_in = 22'h001234;
    e_ack(); e_push(16'h10FF, 8'h34, 1); e_push(16'h10FE, 8'h12, 0); e_vect(22'h00000A);
    run(0, 1, 3, "t1_lat");
    chk("t1_sp", gi[0].sp, 16'h10FD);
    chk("t1_sreg", gi[0].sreg, 0);

    // 2: masked interrupt
    @(posedge clk); #1 irq_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_busy", gi[0].busy, 0);
    end
    @(posedge clk); #1 irq_req = 1'b0;

    // 3: RETI, 16-bit PC
    setenv(0, 16'h10FD, 1'b0);
    e_inc(); e_rd(16'h10FE); e_inc(); e_rd(16'h10FF); e_fin(22'h001234);
    run(1, 0, 5, "t3_lat");
    chk("t3_sp", gi[0].sp, 16'h10FF);
    chk("t3_sreg", gi[0].sreg, 1);

    // 4: round trip, 22-bit PC, SP wraps
    setenv(1, 16'h0002, 1'b1);
    irq_vec = 6'd3; pc_in = 22'h2ABCDE;
    e_ack(); e_push(16'h0002, 8'hDE, 1); e_push(16'h0001, 8'hBC, 0);
    e_push(16'h0000, 8'h2A, 0); e_vect(22'h000006);
    run(0, 1, 4, "t4_entry_lat");
    chk("t4_sp_wrap", gi[1].sp, 16'hFFFF);
    e_inc(); e_rd(16'h0000); e_inc(); e_rd(16'h0001); e_inc(); e_rd(16'h0002);
    e_fin(22'h2ABCDE);
    run(1, 0, 7, "t4_exit_lat");
    chk("t4_sp", gi[1].sp, 16'h0002);
    chk("t4_sreg", gi[1].sreg, 1);

    // 5: RETI wins over IRQ; IRQ then taken, with a stall in PUSH1
    setenv(0, 16'h10FD, 1'b1);
    irq_vec = 6'd2; pc_in = 22'h000456;
    e_inc(); e_rd(16'h10FE); e_inc(); e_rd(16'h10FF); e_fin(22'h001234);
    e_ack(); e_push(16'h10FF, 8'h56, 1); e_push(16'h10FE, 8'h04, 0); e_vect(22'h000004);
    @(posedge clk); #1 reti_req = 1'b1; irq_req = 1'b1;
    @(negedge clk);
    @(negedge clk); reti_req = 1'b0;
    for (n = 0; n < 20 && !gi[0].ack; n++) @(negedge clk);
    chk("t5_ack_seen", {31'd0, gi[0].ack}, 1);
    @(negedge clk); irq_req = 1'b0;
    chk("t5_push0", {31'd0, gi[0].we}, 1);
    @(posedge clk); #1 cp2en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_stall_busy", gi[0].busy, 1);
    end
    @(posedge clk); #1 cp2en = 1'b1;
    for (n = 0; n < 20 && !gi[0].done; n++) @(negedge clk);
    chk("t5_done_seen", {31'd0, gi[0].done}, 1);
    @(negedge clk);
    chk("t5_idle", gi[0].busy, 0);
    chk("t5_sp", gi[0].sp, 16'h10FD);
    chk("t5_mem_hi", gi[0].mem[16'h10FF], 8'h56);
    chk("t5_mem_lo", gi[0].mem[16'h10FE], 8'h04);
    chk("t5_drain", q.size(), 0);

    // 6: reset during RD0, then a clean entry
    setenv(0, 16'h10FD, 1'b0);
    e_inc(); e_rd(16'h10FE);
    @(posedge clk); #1 reti_req = 1'b1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 1) reti_req = 1'b0;
      if (gi[0].re) break;
    end
    chk("t6_rd0_seen", {31'd0, gi[0].re}, 1);
    #1 ireset = 1'b1;
    @(posedge clk); #1 ireset = 1'b0;
    @(negedge clk);
    chk("t6_out", {31'd0, gi[0].act != '0}, 0);
    chk("t6_busy", gi[0].busy, 0);
    chk("t6_sp", gi[0].sp, 16'h10FE);
    chk("t6_drain", q.size(), 0);
    setenv(0, 16'h2000, 1'b1);
    irq_vec = 6'd1; pc_in = 22'h000100;
    e_ack(); e_push(16'h2000, 8'h00, 1); e_push(16'h1FFF, 8'h01, 0); e_vect(22'h000002);
    run(0, 1, 3, "t6_after_lat");
    chk("t6_after_sp", gi[0].sp, 16'h1FFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
